alu_result_demux: RTL and testbench
===================================

# alu_result_demux

Registered 1-to-4 demultiplexer that routes 32-bit ALU results to one of four consumer ports selected by a 2-bit destination code. It performs the inverse of the 4:1 result select. Each destination has a one-entry holding slot with a valid/ready handshake, so a stalled consumer back-pressures only the traffic addressed to it. The block sits between the ALU output stage and the downstream consumers: register file write port, flag unit, debug tap and spare.

## Interface
- WIDTH, 32: data width of every path.
- CNT_W, 8: width of each per-port delivery counter (used only with DEMUX_STATS_EN).

- clk  input  1  Rising-edge clock; the only clock.
- rst_n  input  1  Reset; asynchronous and active-low.
- in_valid  input  1  Producer has a result on in_data.
- in_ready  output  1  Block can accept the result addressed by in_sel this cycle.
- in_sel  input  2  Destination port index, 0..3; S1 is bit 1 and S0 is bit 0.
- in_data  input  WIDTH  Result word.
- out_valid  output  4  Bit k set: slot k holds a word.
- out_ready  input  4  Bit k set: consumer k takes the word this cycle.
- out_data  output  4*WIDTH  Slot k word in bits [k*WIDTH +: WIDTH].
- deliv_cnt  output  4*CNT_W  Per-port delivery counters; present only with DEMUX_STATS_EN.

## Operation
- Per-slot state machine with two states, EMPTY and FULL. Slot k is FULL exactly when out_valid[k]=1.
- Accept condition: in_valid && in_ready. The accept targets slot in_sel only.
- in_ready = (slot[in_sel] is EMPTY) || out_ready[in_sel]. This path is combinational from in_sel and out_ready.
  - in_sel is don't-care when in_valid=0, but in_ready is still driven from it.
- Slot k transitions:
  - EMPTY, accept to k: go FULL and load in_data.
  - FULL, out_ready[k], no accept to k: go EMPTY; out_data keeps its last value.
  - FULL, out_ready[k], accept to k: stay FULL and load the new word. Full throughput, no bubble.
  - FULL, !out_ready[k]: hold. out_data[k] must stay stable and in_ready stays 0 for sel=k.
  - Any other combination: no change.
- Slots are independent. A stall on port k never blocks accepts addressed to another port.
- Ordering is preserved per port only. No ordering is defined across ports.
- No combinational path from in_data to out_data.

## Timing
- Latency: a word accepted at edge N is visible with out_valid[k]=1 immediately after edge N.
- A consumer with out_ready held high sustains one word per cycle per port.
- Reset value of every output:
  - out_valid = 4'b0000.
  - out_data = 0.
  - deliv_cnt = 0.
  - in_ready then reflects EMPTY slots, so it reads 1.
- Reset asserted mid-operation clears all slots immediately, without waiting for a clock edge. Held words are discarded, not delivered.
- Reset deassertion is sampled synchronously by the surrounding design. The first accept can occur on the first edge after rst_n rises.

## Configuration
- DEMUX_STATS_EN defined:
  - deliv_cnt port exists.
  - Counter k increments on every cycle with out_valid[k] && out_ready[k].
  - Counters wrap from 2^CNT_W-1 to 0 with no saturation and no flag.
- DEMUX_STATS_EN undefined: deliv_cnt port and all counter logic are absent. Datapath behaviour is identical in both builds.

## Structure
- Package alu_demux_pkg contains:
  - NUM_DEST = 4.
  - typedef dest_sel_t (2-bit).
  - typedef slot_state_t {EMPTY, FULL}.
- Sub-module demux_out_slot: one-entry holding register with its EMPTY/FULL state machine, plus the optional counter. It is instantiated four times; the top level contains only the select decode and the in_ready mux.

## Test plan
- Reset, then all out_ready=1. Send 0xA5A5_0001 to sel=0, 0x0000_0002 to sel=1, 0x0000_0003 to sel=2 and 0xFFFF_FFFF to sel=3 on consecutive cycles. Each word must appear on its port one cycle later with exactly one out_valid bit set per accept, and in_ready must stay 1 throughout.
- Stall: hold out_ready[2]=0 and send 0x1234_5678 to sel=2. out_valid[2]=1 and the data holds. A second sel=2 word must see in_ready=0, while a sel=0 word is accepted in the same stall window.
- Back-to-back on one port: out_ready[1]=1, eight words 1..8 to sel=1 on consecutive cycles. Port 1 must deliver 1..8 in order, one per cycle, with no bubble.
- Simultaneous drain and refill: slot 3 holds 0xDEAD_BEEF and out_ready[3] rises in the same cycle a sel=3 accept of 0xCAFE_F00D occurs. The next cycle must show out_valid[3]=1 and data 0xCAFE_F00D.
- Reset mid-stall: slots 0 and 2 FULL, then pulse rst_n low between clock edges. out_valid must go to 0000 immediately, out_data to 0, and nothing may be delivered after reset.
- With DEMUX_STATS_EN and CNT_W=8: 257 deliveries on port 0 give deliv_cnt[7:0]=1, and the other counters read 0.

Source files
------------

// File: rtl/alu_demux_pkg.sv
// rtl/alu_demux_pkg.sv - shared types for the ALU result demultiplexer
package alu_demux_pkg;

  localparam int NUM_DEST = 4;

  typedef logic [1:0] dest_sel_t;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/demux_out_slot.sv
// rtl/demux_out_slot.sv - one-entry valid/ready holding slot for one destination
// Delivery counter is built only when DEMUX_STATS_EN is defined.
module demux_out_slot
  import alu_demux_pkg::*;
#(
  parameter int WIDTH = 32
`ifdef DEMUX_STATS_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o
`ifdef DEMUX_STATS_EN
  , output logic [CNT_W-1:0] deliv_cnt_o
`endif
);

  slot_state_t      state_q;
  logic [WIDTH-1:0] data_q;

  // A load while FULL only happens when the consumer is taking the old word,
  // so the refill path never needs to look at out_ready_i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (load_i) begin
            state_q <= FULL;
            data_q  <= data_i;
          end
        end
        FULL: begin
          if (load_i) begin
            data_q <= data_i;
          end else if (out_ready_i) begin
            state_q <= EMPTY;
          end
        end
      endcase
    end
  end

  assign out_valid_o = (state_q == FULL);
  assign out_data_o  = data_q;

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (out_valid_o && out_ready_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign deliv_cnt_o = cnt_q;
`endif

endmodule

// File: rtl/alu_result_demux.sv
// rtl/alu_result_demux.sv - registered 1-to-4 ALU result demux with per-port slots
// Optional per-port delivery counters under DEMUX_STATS_EN.
module alu_result_demux
  import alu_demux_pkg::*;
#(
  parameter int WIDTH = 32
`ifdef DEMUX_STATS_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_sel,
  input  logic [WIDTH-1:0]          in_data,
  output logic [NUM_DEST-1:0]       out_valid,
  input  logic [NUM_DEST-1:0]       out_ready,
  output logic [NUM_DEST*WIDTH-1:0] out_data
`ifdef DEMUX_STATS_EN
  , output logic [NUM_DEST*CNT_W-1:0] deliv_cnt
`endif
);

  dest_sel_t           sel;
  logic                accept;
  logic [NUM_DEST-1:0] load;

  assign sel = in_sel;

  // in_ready follows in_sel even when in_valid is low.
  assign in_ready = !out_valid[sel] || out_ready[sel];
  assign accept   = in_valid && in_ready;

  always_comb begin
    load      = '0;
    load[sel] = accept;
  end

  for (genvar k = 0; k < NUM_DEST; k++) begin : g_slot
    demux_out_slot #(
      .WIDTH (WIDTH)
`ifdef DEMUX_STATS_EN
      , .CNT_W (CNT_W)
`endif
    ) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (load[k]),
      .data_i      (in_data),
      .out_ready_i (out_ready[k]),
      .out_valid_o (out_valid[k]),
      .out_data_o  (out_data[k*WIDTH +: WIDTH])
`ifdef DEMUX_STATS_EN
      , .deliv_cnt_o (deliv_cnt[k*CNT_W +: CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_alu_result_demux.sv
// tb/tb_alu_result_demux.sv - directed self-checking bench for alu_result_demux
// Stats checks are compiled in when DEMUX_STATS_EN is defined.
module tb_alu_result_demux;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_sel;
  logic [31:0]  in_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [127:0] out_data;
`ifdef DEMUX_STATS_EN
  logic [31:0]  deliv_cnt;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;

  alu_result_demux dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DEMUX_STATS_EN
    , .deliv_cnt (deliv_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] sel, input logic [31:0] data);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
  endtask

  function automatic logic [31:0] word(input int k);
    return out_data[k*32 +: 32];
  endfunction

  logic [31:0] vec_data [4];

  initial begin
    vec_data[0] = 32'hA5A5_0001;
    vec_data[1] = 32'h0000_0002;
    vec_data[2] = 32'h0000_0003;
    vec_data[3] = 32'hFFFF_FFFF;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = '0;
    out_ready = 4'h0;
    #12;
    check("rst_valid", out_valid, 4'b0000);
    check("rst_data", out_data, 128'h0);
    check("rst_ready", in_ready, 1'b1);
`ifdef DEMUX_STATS_EN
    check("rst_cnt", deliv_cnt, 32'h0);
`endif
    rst_n = 1'b1;

    // Route one word to each port on consecutive cycles
    out_ready = 4'hF;
    for (int k = 0; k < 4; k++) begin
      send(2'(k), vec_data[k]);
      #1;
      check($sformatf("route_ready%0d", k), in_ready, 1'b1);
      tick();
      check($sformatf("route_valid%0d", k), out_valid, 4'b0001 << k);
      check($sformatf("route_data%0d", k), word(k), vec_data[k]);
    end
    in_valid = 1'b0;
    tick();
    check("route_drain", out_valid, 4'b0000);

    // Stall port 2 while port 0 keeps flowing
    out_ready = 4'b1011;
    send(2'd2, 32'h1234_5678);
    tick();
    check("stall_valid", out_valid, 4'b0100);
    check("stall_data", word(2), 32'h1234_5678);
    send(2'd2, 32'h0000_0BAD);
    #1;
    check("stall_ready2", in_ready, 1'b0);
    tick();
    check("stall_hold", word(2), 32'h1234_5678);
    send(2'd0, 32'h0000_0055);
    #1;
    check("stall_ready0", in_ready, 1'b1);
    tick();
    check("stall_valid2", out_valid, 4'b0101);
    check("stall_data0", word(0), 32'h0000_0055);
    check("stall_data2", word(2), 32'h1234_5678);
    in_valid = 1'b0;
    tick();
    check("stall_only2", out_valid, 4'b0100);
    out_ready = 4'hF;
    tick();
    check("stall_release", out_valid, 4'b0000);

    // Back-to-back on port 1
    for (int i = 1; i <= 8; i++) begin
      send(2'd1, 32'(i));
      #1;
      check($sformatf("b2b_ready%0d", i), in_ready, 1'b1);
      tick();
      check($sformatf("b2b_valid%0d", i), out_valid, 4'b0010);
      check($sformatf("b2b_data%0d", i), word(1), 32'(i));
    end
    in_valid = 1'b0;
    tick();
    check("b2b_drain", out_valid, 4'b0000);

    // Drain and refill port 3 in the same cycle
    out_ready = 4'b0111;
    send(2'd3, 32'hDEAD_BEEF);
    tick();
    check("refill_first", word(3), 32'hDEAD_BEEF);
    out_ready = 4'hF;
    send(2'd3, 32'hCAFE_F00D);
    #1;
    check("refill_ready", in_ready, 1'b1);
    tick();
    check("refill_valid", out_valid, 4'b1000);
    check("refill_data", word(3), 32'hCAFE_F00D);
    in_valid = 1'b0;
    tick();
    check("refill_drain", out_valid, 4'b0000);

    // Asynchronous reset while slots 0 and 2 are stalled
    out_ready = 4'h0;
    send(2'd0, 32'h0000_0011);
    tick();
    send(2'd2, 32'h0000_0022);
    tick();
    in_valid = 1'b0;
    check("mid_full", out_valid, 4'b0101);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 4'b0000);
    check("mid_rst_data", out_data, 128'h0);
    #1 rst_n = 1'b1;
    out_ready = 4'hF;
    tick();
    check("mid_post_valid", out_valid, 4'b0000);

`ifdef DEMUX_STATS_EN
    // 257 deliveries on port 0 wrap an 8-bit counter to 1
    for (int i = 0; i < 257; i++) begin
      send(2'd0, 32'(i));
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("cnt_wrap", deliv_cnt, 32'h0000_0001);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
